// File: rtl/serial_deser_pkg.sv
// Shared types and defaults for the serial-to-parallel receive stage.
package serial_deser_pkg;

    localparam int DESER_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } deser_state_t;

endpackage

// File: rtl/deser_bit_cnt.sv
// Bit counter for the deserializer: clear (optionally counting the same-cycle bit),
// increment, and a terminal-count flag raised when the next bit completes the word.
module deser_bit_cnt #(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q;

    assign tc = (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= inc ? CW'(1) : '0;
        end else if (inc) begin
            cnt_q <= tc ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver: collects an LSB-first bit stream into W-bit words
// and offers them on a valid/ready port with a sticky overrun flag.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int W = DESER_W
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic         bit_vld,
    input  logic         bit_in,
    input  logic         out_rdy,
    input  logic         ovf_clr,
    output logic [W-1:0] data_out,
    output logic         out_vld,
    output logic         busy,
    output logic         ovf
);

    // The collector keeps only the W-1 bits already received; the final bit is
    // taken straight from bit_in when the word completes.
    typedef logic [W-2:0] col_t;

    deser_state_t state_q, state_d;
    col_t         col_q, col_d;
    logic [W-1:0] data_d;
    logic         vld_d, ovf_d;
    logic         cnt_clr, cnt_inc, cnt_tc;
    logic         complete, overrun;

    deser_bit_cnt #(.W(W)) u_bit_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            col_q    <= '0;
            data_out <= '0;
            out_vld  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            data_out <= data_d;
            out_vld  <= vld_d;
            ovf      <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        complete = 1'b0;
        if (start) begin
            state_d = RECV;
            cnt_clr = 1'b1;
            cnt_inc = bit_vld;
            col_d   = '0;
            if (bit_vld) begin
                col_d[W-2] = bit_in;
            end
        end else if (state_q == RECV && bit_vld) begin
            cnt_inc = 1'b1;
            col_d   = col_t'({bit_in, col_q} >> 1);
            if (cnt_tc) begin
                complete = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_comb begin
        data_d  = data_out;
        vld_d   = out_vld;
        ovf_d   = ovf;
        overrun = complete && out_vld && !out_rdy;
        if (complete && !overrun) begin
            data_d = {bit_in, col_q};
            vld_d  = 1'b1;
        end else if (out_vld && out_rdy) begin
            vld_d = 1'b0;
        end
        // A fresh overrun outranks a simultaneous clear.
        if (overrun) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    assign busy = (state_q == RECV);

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: directed word scenarios plus a random
// stream, compared every cycle against a bit-indexed word-assembly model.
module tb_serial_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         start = 1'b0;
    logic         bit_vld = 1'b0;
    logic         bit_in = 1'b0;
    logic         out_rdy = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [W-1:0] data_out;
    logic         out_vld;
    logic         busy;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_active = 1'b0;
    int           m_n = 0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] m_data = '0;
    bit           m_vld = 1'b0;
    bit           m_ovf = 1'b0;
    bit           m_done;
    bit           m_lost;

    serial_deser #(.W(W)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .bit_vld  (bit_vld),
        .bit_in   (bit_in),
        .out_rdy  (out_rdy),
        .ovf_clr  (ovf_clr),
        .data_out (data_out),
        .out_vld  (out_vld),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word i is built by placing bit k of the stream at position k.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_active = 1'b0;
            m_n      = 0;
            m_acc    = '0;
            m_data   = '0;
            m_vld    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_n      = 0;
                m_acc    = '0;
                if (bit_vld) begin
                    m_acc[0] = bit_in;
                    m_n      = 1;
                end
            end else if (m_active && bit_vld) begin
                m_acc[m_n] = bit_in;
                m_n++;
                if (m_n == W) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                    m_n      = 0;
                end
            end
            m_lost = m_done && m_vld && !out_rdy;
            if (m_done && !m_lost) begin
                m_data = m_acc;
                m_vld  = 1'b1;
            end else if (m_vld && out_rdy) begin
                m_vld = 1'b0;
            end
            if (m_lost) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cyc_data_out", 32'(data_out), 32'(m_data));
        chk("cyc_out_vld", 32'(out_vld), 32'(m_vld));
        chk("cyc_busy", 32'(busy), 32'(m_active));
        chk("cyc_ovf", 32'(ovf), 32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] v, input bit with_start_bit, input bit rdy_last);
        start = 1'b1;
        if (with_start_bit) begin
            bit_vld = 1'b1;
            bit_in  = v[0];
        end else begin
            bit_vld = 1'b0;
            bit_in  = 1'bx;
        end
        tick();
        start = 1'b0;
        for (int i = (with_start_bit ? 1 : 0); i < W; i++) begin
            bit_vld = 1'b1;
            bit_in  = v[i];
            if (i == W - 1 && rdy_last) out_rdy = 1'b1;
            tick();
            if (i < W - 1) chk("busy_mid_word", 32'(busy), 32'd1);
        end
        bit_vld = 1'b0;
        bit_in  = 1'bx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        out_rdy = 1'b1;
        #11;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_b = 1'b1;
        tick();

        // Stray bits while idle must be ignored
        bit_vld = 1'b1;
        bit_in  = 1'bx;
        tick();
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_vld", 32'(out_vld), 32'd0);

        send_word(8'hA5, 1'b0, 1'b0);
        chk("a5_data", 32'(data_out), 32'hA5);
        chk("a5_vld", 32'(out_vld), 32'd1);
        chk("a5_busy_done", 32'(busy), 32'd0);
        tick();
        chk("a5_vld_drop", 32'(out_vld), 32'd0);
        chk("a5_data_held", 32'(data_out), 32'hA5);

        send_word(8'h0F, 1'b1, 1'b0);
        chk("0f_data", 32'(data_out), 32'h0F);
        chk("0f_vld", 32'(out_vld), 32'd1);
        tick();

        out_rdy = 1'b0;
        send_word(8'h3C, 1'b0, 1'b0);
        chk("3c_data", 32'(data_out), 32'h3C);
        chk("3c_ovf_clear", 32'(ovf), 32'd0);
        send_word(8'hC3, 1'b0, 1'b0);
        chk("ovr_ovf", 32'(ovf), 32'd1);
        chk("ovr_data_kept", 32'(data_out), 32'h3C);
        chk("ovr_vld", 32'(out_vld), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("ovf_clr_vld", 32'(out_vld), 32'd1);

        send_word(8'hC3, 1'b0, 1'b1);
        chk("same_edge_data", 32'(data_out), 32'hC3);
        chk("same_edge_vld", 32'(out_vld), 32'd1);
        chk("same_edge_ovf", 32'(ovf), 32'd0);
        tick();
        chk("same_edge_drain", 32'(out_vld), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bit_vld = 1'b1;
            bit_in  = 1'b1;
            tick();
        end
        bit_vld = 1'b0;
        chk("abort_partial_vld", 32'(out_vld), 32'd0);
        send_word(8'h81, 1'b0, 1'b0);
        chk("abort_data", 32'(data_out), 32'h81);
        chk("abort_vld", 32'(out_vld), 32'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_vld = 1'b1;
            bit_in  = 1'(i & 1);
            tick();
        end
        bit_vld = 1'b1;
        bit_in  = 1'b1;
        #2 rst_b = 1'b0;
        #1;
        chk("arst_data", 32'(data_out), 32'd0);
        chk("arst_vld", 32'(out_vld), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        bit_vld = 1'b0;
        tick();
        tick();
        #2 rst_b = 1'b1;
        tick();
        send_word(8'h55, 1'b0, 1'b0);
        chk("post_rst_data", 32'(data_out), 32'h55);
        chk("post_rst_vld", 32'(out_vld), 32'd1);

        for (int i = 0; i < 800; i++) begin
            start   = ($urandom_range(0, 11) == 0);
            bit_vld = ($urandom_range(0, 3) != 0);
            bit_in  = 1'($urandom_range(0, 1));
            out_rdy = ($urandom_range(0, 2) == 0);
            ovf_clr = ($urandom_range(0, 19) == 0);
            if (i == 400) begin
                #1 rst_b = 1'b0;
                #1 rst_b = 1'b1;
            end
            tick();
        end
        start   = 1'b0;
        bit_vld = 1'b0;
        ovf_clr = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
